// File: rtl/ground_scroller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ground_scroller_pkg
//  Description : Shared types and sizing constants for the ground scroller
//                (scroll state encoding, tile/offset widths, colour and
//                raster coordinate widths, packed RGB pixel type).
//  Revision    : 1.0  initial release
// ============================================================================
package ground_scroller_pkg;

    localparam int TILE_W   = 16;   // tile edge length in pixels
    localparam int OFFSET_W = 4;    // log2(TILE_W): width of tile-local coordinates
    localparam int COLOR_W  = 8;    // bits per colour channel
    localparam int COORD_W  = 11;   // raster coordinate width

    // Scroll state machine encoding; values are visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } scroll_state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/ground_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ground_scroll_ctrl
//  Description : Scroll state machine (IDLE / RUN / HALT) and the horizontal
//                scroll offset register. The offset advances by SPEED once
//                per frame_tick while running, so it never changes mid-frame.
//  Ports       : clk, rst_n            clock, async active-low reset
//                frame_tick            one pulse per frame
//                start, game_over      game control pulses
//                scroll_offset         current offset (mod TILE)
//                state                 current scroll state
//  Revision    : 1.0  initial release
// ============================================================================
module ground_scroll_ctrl
    import ground_scroller_pkg::*;
#(
    parameter int SPEED = 2,
    parameter int TILE  = TILE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                start,
    input  logic                game_over,
    output logic [OFFSET_W-1:0] scroll_offset,
    output scroll_state_t       state
);

    localparam logic [OFFSET_W-1:0] C_SPEED = OFFSET_W'(SPEED);
    localparam logic [OFFSET_W-1:0] C_MASK  = OFFSET_W'(TILE - 1);

    scroll_state_t         r_state;
    logic [OFFSET_W-1:0]   r_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_offset <= '0;
        end else begin
            // The advance looks at the state held before this edge, so a
            // game_over arriving with frame_tick still lets this frame move.
            if (frame_tick && (r_state == ST_RUN)) begin
                r_offset <= (r_offset + C_SPEED) & C_MASK;
            end

            case (r_state)
                ST_IDLE: begin
                    // game_over is meaningless before the game starts
                    if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // game_over has priority over a simultaneous start
                    if (game_over) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // No offset advance can happen in HALT, so clearing here
                    // never competes with the update above.
                    if (start) begin
                        r_state  <= ST_IDLE;
                        r_offset <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign scroll_offset = r_offset;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: rtl/ground_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : ground_scroller
//  Description : Pixel pipeline stage in front of the 16x16 grass tile ROM.
//                Maps raster position to tile-local coordinates inside the
//                ground band (with horizontal scroll), drives the ROM with
//                its required timing and composites the returned tile over
//                the background using the ROM mask. Latency 3 cycles.
//  Ports       : clk, rst_n                    clock, async active-low reset
//                pix_x, pix_y, pix_valid       raster position / qualifier
//                bg_r, bg_g, bg_b              background pixel
//                frame_tick, start, game_over  scroll control
//                sprite_x, sprite_y            tile ROM column / row
//                tile_r, tile_g, tile_b        tile ROM colour
//                tile_mask                     tile ROM opacity
//                out_r, out_g, out_b           composited pixel
//                out_valid                     pix_valid aligned with out_*
//                scroll_offset, state          scroll status
//  Revision    : 1.0  initial release
// ============================================================================
module ground_scroller
    import ground_scroller_pkg::*;
#(
    parameter int GROUND_Y = 400,
    parameter int SPEED    = 2,
    parameter int TILE     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COORD_W-1:0]  pix_x,
    input  logic [COORD_W-1:0]  pix_y,
    input  logic                pix_valid,
    input  logic [COLOR_W-1:0]  bg_r,
    input  logic [COLOR_W-1:0]  bg_g,
    input  logic [COLOR_W-1:0]  bg_b,
    input  logic                frame_tick,
    input  logic                start,
    input  logic                game_over,
    output logic [COORD_W-1:0]  sprite_x,
    output logic [COORD_W-1:0]  sprite_y,
    input  logic [COLOR_W-1:0]  tile_r,
    input  logic [COLOR_W-1:0]  tile_g,
    input  logic [COLOR_W-1:0]  tile_b,
    input  logic                tile_mask,
    output logic [COLOR_W-1:0]  out_r,
    output logic [COLOR_W-1:0]  out_g,
    output logic [COLOR_W-1:0]  out_b,
    output logic                out_valid,
    output logic [OFFSET_W-1:0] scroll_offset,
    output logic [1:0]          state
);

    // One extra bit so GROUND_Y+TILE cannot wrap in the band compare.
    localparam logic [COORD_W:0]   C_BAND_LO = (COORD_W+1)'(GROUND_Y);
    localparam logic [COORD_W:0]   C_BAND_HI = (COORD_W+1)'(GROUND_Y + TILE);
    localparam logic [COORD_W-1:0] C_GROUND  = COORD_W'(GROUND_Y);
    localparam logic [COORD_W-1:0] C_MASK    = COORD_W'(TILE - 1);

    // ------------------------------------------------------------------
    // Scroll control
    // ------------------------------------------------------------------
    scroll_state_t       w_state;
    logic [OFFSET_W-1:0] w_offset;

    ground_scroll_ctrl #(
        .SPEED (SPEED),
        .TILE  (TILE)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .start         (start),
        .game_over     (game_over),
        .scroll_offset (w_offset),
        .state         (w_state)
    );

    assign scroll_offset = w_offset;
    assign state         = w_state;

    // ------------------------------------------------------------------
    // Coordinate mapping (combinational, feeds S1)
    // ------------------------------------------------------------------
    logic                w_in_band;
    logic [COORD_W-1:0]  w_x_sum;
    logic [COORD_W-1:0]  w_y_diff;
    logic [OFFSET_W-1:0] w_tile_x;
    logic [OFFSET_W-1:0] w_tile_y;

    assign w_in_band = ({1'b0, pix_y} >= C_BAND_LO) && ({1'b0, pix_y} < C_BAND_HI);
    assign w_x_sum   = pix_x + COORD_W'(w_offset);
    assign w_y_diff  = pix_y - C_GROUND;
    // TILE is a power of two, so masking is the modulo.
    assign w_tile_x  = OFFSET_W'(w_x_sum & C_MASK);
    assign w_tile_y  = OFFSET_W'(w_y_diff & C_MASK);

    // ------------------------------------------------------------------
    // Pipeline: S1 -> S2 -> OUT
    // ------------------------------------------------------------------
    logic [OFFSET_W-1:0] r_s1_tile_x;
    logic [OFFSET_W-1:0] r_s1_tile_y;
    logic                r_s1_in_band;
    rgb_t                r_s1_bg;
    logic                r_s1_valid;

    logic [OFFSET_W-1:0] r_s2_tile_x;
    logic                r_s2_in_band;
    rgb_t                r_s2_bg;
    logic                r_s2_valid;

    rgb_t                r_out;
    logic                r_out_valid;

    rgb_t                w_comp;

    // Off-band coordinates are zeroed at S1 so the ROM sees 0 on both
    // sprite_x and sprite_y for every pixel outside the ground band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_tile_x  <= '0;
            r_s1_tile_y  <= '0;
            r_s1_in_band <= 1'b0;
            r_s1_bg      <= '0;
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_tile_x  <= w_in_band ? w_tile_x : '0;
            r_s1_tile_y  <= w_in_band ? w_tile_y : '0;
            r_s1_in_band <= w_in_band;
            r_s1_bg      <= '{r: bg_r, g: bg_g, b: bg_b};
            r_s1_valid   <= pix_valid;
        end
    end

    // The ROM latches its row from sprite_y (S1) on this same edge, so after
    // it the row data and the S2 column are aligned for one full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_tile_x  <= '0;
            r_s2_in_band <= 1'b0;
            r_s2_bg      <= '0;
            r_s2_valid   <= 1'b0;
        end else begin
            r_s2_tile_x  <= r_s1_tile_x;
            r_s2_in_band <= r_s1_in_band;
            r_s2_bg      <= r_s1_bg;
            r_s2_valid   <= r_s1_valid;
        end
    end

    // Compositing: ROM output is only trusted inside the band.
    always_comb begin
        w_comp = r_s2_bg;
        if (!r_s2_valid) begin
            w_comp = '0;
        end else if (r_s2_in_band && tile_mask) begin
            w_comp = '{r: tile_r, g: tile_g, b: tile_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_comp;
            r_out_valid <= r_s2_valid;
        end
    end

    assign sprite_y  = COORD_W'(r_s1_tile_y);
    assign sprite_x  = COORD_W'(r_s2_tile_x);
    assign out_r     = r_out.r;
    assign out_g     = r_out.g;
    assign out_b     = r_out.b;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_ground_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ground_scroller
//  Description : Directed self-checking bench for ground_scroller with a
//                behavioural tile ROM (constant colour AA/BB/CC, selectable
//                mask).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ground_scroller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pix_x = '0;
    logic [10:0] pix_y = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  bg_r = '0, bg_g = '0, bg_b = '0;
    logic        frame_tick = 1'b0, start = 1'b0, game_over = 1'b0;
    logic [10:0] sprite_x, sprite_y;
    logic [7:0]  tile_r, tile_g, tile_b;
    logic        tile_mask;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_valid;
    logic [3:0]  scroll_offset;
    logic [1:0]  state;

    logic        rom_mask = 1'b1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign tile_r    = 8'hAA;
    assign tile_g    = 8'hBB;
    assign tile_b    = 8'hCC;
    assign tile_mask = rom_mask;

    ground_scroller #(.GROUND_Y(400), .SPEED(2), .TILE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .frame_tick(frame_tick), .start(start), .game_over(game_over),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .tile_r(tile_r), .tile_g(tile_g), .tile_b(tile_b), .tile_mask(tile_mask),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_valid(out_valid),
        .scroll_offset(scroll_offset), .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [10:0] x, input logic [10:0] y, input logic v,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pix_x = x; pix_y = y; pix_valid = v; bg_r = r; bg_g = g; bg_b = b;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h0) begin errors++; $display("FAIL reset_out got=%h exp=000000", {out_r, out_g, out_b}); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (sprite_x !== 11'd0 || sprite_y !== 11'd0) begin errors++; $display("FAIL reset_sprite got=%0d/%0d exp=0/0", sprite_x, sprite_y); end
        checks++; if (scroll_offset !== 4'd0) begin errors++; $display("FAIL reset_offset got=%0d exp=0", scroll_offset); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_band_pixel();
        rom_mask = 1'b1;
        set_pix(11'd5, 11'd400, 1'b1, 8'h01, 8'h02, 8'h03);
        tick(); set_pix(0, 0, 0, 0, 0, 0);
        checks++; if (sprite_y !== 11'd0) begin errors++; $display("FAIL band_sprite_y got=%0d exp=0", sprite_y); end
        tick();
        checks++; if (sprite_x !== 11'd5) begin errors++; $display("FAIL band_sprite_x got=%0d exp=5", sprite_x); end
        tick();
        checks++; if ({out_r, out_g, out_b} !== 24'hAABBCC) begin errors++; $display("FAIL band_out got=%h exp=aabbcc", {out_r, out_g, out_b}); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL band_valid got=%b exp=1", out_valid); end
        set_pix(11'd7, 11'd403, 1'b1, 8'h01, 8'h02, 8'h03);
        tick(); set_pix(0, 0, 0, 0, 0, 0);
        checks++; if (sprite_y !== 11'd3) begin errors++; $display("FAIL band_row3 got=%0d exp=3", sprite_y); end
        tick();
        checks++; if (sprite_x !== 11'd7) begin errors++; $display("FAIL band_col7 got=%0d exp=7", sprite_x); end
        tick();
    endtask

    task automatic test_off_band();
        set_pix(11'd9, 11'd399, 1'b1, 8'h10, 8'h20, 8'h30);
        tick(); set_pix(0, 0, 0, 0, 0, 0);
        checks++; if (sprite_y !== 11'd0) begin errors++; $display("FAIL above_sprite_y got=%0d exp=0", sprite_y); end
        tick();
        checks++; if (sprite_x !== 11'd0) begin errors++; $display("FAIL above_sprite_x got=%0d exp=0", sprite_x); end
        tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h102030 || out_valid !== 1'b1) begin errors++; $display("FAIL above_out got=%h/%b exp=102030/1", {out_r, out_g, out_b}, out_valid); end
        set_pix(11'd9, 11'd416, 1'b1, 8'h44, 8'h55, 8'h66);
        tick(); set_pix(0, 0, 0, 0, 0, 0);
        checks++; if (sprite_y !== 11'd0) begin errors++; $display("FAIL below_sprite_y got=%0d exp=0", sprite_y); end
        tick();
        checks++; if (sprite_x !== 11'd0) begin errors++; $display("FAIL below_sprite_x got=%0d exp=0", sprite_x); end
        tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h445566) begin errors++; $display("FAIL below_out got=%h exp=445566", {out_r, out_g, out_b}); end
    endtask

    task automatic test_scroll();
        logic [3:0] exp_off;
        set_pix(11'd3, 11'd408, 1'b1, 0, 0, 0);
        tick(); set_pix(0, 0, 0, 0, 0, 0); tick();
        checks++; if (sprite_x !== 11'd3) begin errors++; $display("FAIL scroll_x_off0 got=%0d exp=3", sprite_x); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_run got=%0d exp=1", state); end
        for (int i = 1; i <= 8; i++) begin
            pulse_tick();
            exp_off = 4'((2 * i) % 16);
            checks++; if (scroll_offset !== exp_off) begin errors++; $display("FAIL scroll_step%0d got=%0d exp=%0d", i, scroll_offset, exp_off); end
            if (i == 3) begin
                // offset 6: x=3 -> 9, x=13 -> 19 mod 16 = 3 (back to back)
                set_pix(11'd3, 11'd408, 1'b1, 0, 0, 0); tick();
                set_pix(11'd13, 11'd408, 1'b1, 0, 0, 0); tick();
                set_pix(0, 0, 0, 0, 0, 0);
                checks++; if (sprite_x !== 11'd9) begin errors++; $display("FAIL scroll_x_off6 got=%0d exp=9", sprite_x); end
                tick();
                checks++; if (sprite_x !== 11'd3) begin errors++; $display("FAIL scroll_x_wrap got=%0d exp=3", sprite_x); end
            end
        end
    endtask

    task automatic test_halt();
        pulse_tick();
        checks++; if (scroll_offset !== 4'd2) begin errors++; $display("FAIL halt_pre_off got=%0d exp=2", scroll_offset); end
        start = 1'b1; game_over = 1'b1; tick(); start = 1'b0; game_over = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL halt_priority got=%0d exp=2", state); end
        pulse_tick();
        checks++; if (scroll_offset !== 4'd2) begin errors++; $display("FAIL halt_hold got=%0d exp=2", scroll_offset); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state !== 2'd0 || scroll_offset !== 4'd0) begin errors++; $display("FAIL halt_restart got=%0d/%0d exp=0/0", state, scroll_offset); end
        game_over = 1'b1; tick(); game_over = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_ignore_go got=%0d exp=0", state); end
        pulse_tick();
        checks++; if (scroll_offset !== 4'd0) begin errors++; $display("FAIL idle_hold got=%0d exp=0", scroll_offset); end
    endtask

    task automatic test_mask_valid();
        rom_mask = 1'b0;
        set_pix(11'd4, 11'd410, 1'b1, 8'h11, 8'h22, 8'h33);
        tick(); set_pix(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h112233) begin errors++; $display("FAIL mask0_out got=%h exp=112233", {out_r, out_g, out_b}); end
        rom_mask = 1'b1;
        set_pix(11'd4, 11'd410, 1'b0, 8'h77, 8'h88, 8'h99);
        tick(); tick(); tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL invalid_out got=%h/%b exp=000000/0", {out_r, out_g, out_b}, out_valid); end
        set_pix(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        rom_mask = 1'b1;
        set_pix(11'd1, 11'd405, 1'b1, 8'h01, 8'h02, 8'h03); tick();
        set_pix(11'd2, 11'd300, 1'b1, 8'h40, 8'h50, 8'h60); tick();
        set_pix(0, 0, 0, 8'h12, 8'h34, 8'h56); tick();
        checks++; if ({out_r, out_g, out_b} !== 24'hAABBCC) begin errors++; $display("FAIL b2b_first got=%h exp=aabbcc", {out_r, out_g, out_b}); end
        tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h405060 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got=%h/%b exp=405060/1", {out_r, out_g, out_b}, out_valid); end
        tick();
        checks++; if ({out_r, out_g, out_b} !== 24'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_third got=%h/%b exp=000000/0", {out_r, out_g, out_b}, out_valid); end
        set_pix(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        pulse_tick();
        set_pix(11'd1, 11'd402, 1'b1, 8'h01, 8'h02, 8'h03);
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1 || sprite_x !== 11'd3) begin errors++; $display("FAIL full_pipe got=%b/%0d exp=1/3", out_valid, sprite_x); end
        rst_n = 1'b0; #1;
        checks++; if ({out_r, out_g, out_b} !== 24'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_out got=%h/%b exp=000000/0", {out_r, out_g, out_b}, out_valid); end
        checks++; if (sprite_x !== 11'd0 || sprite_y !== 11'd0) begin errors++; $display("FAIL async_rst_sprite got=%0d/%0d exp=0/0", sprite_x, sprite_y); end
        checks++; if (scroll_offset !== 4'd0 || state !== 2'd0) begin errors++; $display("FAIL async_rst_ctrl got=%0d/%0d exp=0/0", scroll_offset, state); end
        tick();
        rst_n = 1'b1; set_pix(0, 0, 0, 0, 0, 0);
        tick(); tick();
        set_pix(11'd1, 11'd402, 1'b1, 8'h01, 8'h02, 8'h03);
        tick(); set_pix(0, 0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_lat1 got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_lat2 got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || {out_r, out_g, out_b} !== 24'hAABBCC) begin errors++; $display("FAIL rel_lat3 got=%b/%h exp=1/aabbcc", out_valid, {out_r, out_g, out_b}); end
    endtask

    initial begin
        test_reset();
        test_band_pixel();
        test_off_band();
        test_scroll();
        test_halt();
        test_mask_valid();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ground_scroller.md
# ground_scroller

Pixel-pipeline stage that sits directly upstream of the 16×16 grass tile ROM and consumes its output. It does four things:
- maps the VGA raster position into tile-local coordinates for the ground band, with a horizontal scroll offset;
- drives the ROM's coordinate inputs with the timing the ROM requires;
- composites the returned tile pixel over the background pixel using the ROM mask;
- runs the scroll state machine (idle / running / halted on game over) that advances the offset once per frame.

## Interface
Parameters:
- GROUND_Y, 400: first raster line of the 16-line ground band.
- SPEED, 2: offset increment per frame tick, in pixels (1..15).
- TILE, 16: tile edge length in pixels; must be a power of two.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_x  in  11  raster column.
- pix_y  in  11  raster row.
- pix_valid  in  1  active-video qualifier for pix_x/pix_y/bg_*.
- bg_r, bg_g, bg_b  in  8 each  background pixel aligned with pix_x/pix_y.
- frame_tick  in  1  one-cycle pulse per frame (vsync start).
- start  in  1  one-cycle pulse: begin or restart the game.
- game_over  in  1  one-cycle pulse: collision detected.
- sprite_x  out  11  column to tile ROM (ix).
- sprite_y  out  11  row to tile ROM (iy).
- tile_r, tile_g, tile_b  in  8 each  tile ROM colour.
- tile_mask  in  1  tile ROM opacity.
- out_r, out_g, out_b  out  8 each  composited pixel.
- out_valid  out  1  pix_valid delayed to align with out_*.
- scroll_offset  out  4  current horizontal offset (log2 TILE bits).
- state  out  2  IDLE=0, RUN=1, HALT=2.

## Operation
- in_band: GROUND_Y ≤ pix_y < GROUND_Y+TILE, evaluated on unsigned 11-bit values.
- tile_x = (pix_x + scroll_offset) mod TILE.
- tile_y = pix_y − GROUND_Y, taking the low 4 bits.
- When in_band=0: sprite_x and sprite_y drive 0, and the ROM output is ignored.
- Composite rule: out = (in_band && tile_mask) ? tile_rgb : bg_rgb.
- When pix_valid=0: out_* are forced to 0.
- State machine transitions:
  - IDLE→RUN on start.
  - RUN→HALT on game_over.
  - HALT→IDLE on start; scroll_offset clears to 0 on this transition.
  - If start and game_over arrive together in RUN, game_over wins.
  - In IDLE, game_over is ignored.
- Offset update:
  - On frame_tick with state==RUN (the current state, sampled before any transition that cycle), scroll_offset ← (scroll_offset + SPEED) mod TILE.
  - The wrap from 15 to 0 is natural 4-bit truncation.
  - The offset is held in IDLE and HALT.
  - The offset changes only on frame_tick, so there is no intra-frame tearing.

## Timing
- The tile ROM registers its row select on iy at the clock edge and decodes the column on ix combinationally. The pipeline therefore has three stages:
  - **Edge 1 (S1):** register tile_y, tile_x, in_band, bg, pix_valid. sprite_y is driven from S1.
  - **Edge 2 (S2):** copy S1 into S2. sprite_x is driven from S2. The ROM row is latched on this edge, so tile_* and tile_mask are valid combinationally during the following cycle.
  - **Edge 3 (OUT):** register the composited pixel into out_* and out_valid.
- Latency from pix_* to out_* is exactly 3 cycles. Throughput is one pixel per cycle; there are no stalls.
- Reset values:
  - all pipeline registers 0;
  - out_r/g/b = 0, out_valid = 0;
  - sprite_x = sprite_y = 0;
  - scroll_offset = 0, state = IDLE.
- Reset asserted mid-frame clears everything asynchronously. The first valid output appears 3 cycles after the first pix_valid following deassertion.
- frame_tick, start and game_over take effect on the edge where they are sampled high. Their effect is visible on scroll_offset/state one cycle later.

## Structure
- Shared package contains:
  - state enum (IDLE, RUN, HALT);
  - TILE_W=16 and OFFSET_W=4;
  - COLOR_W=8 and COORD_W=11.
- Sub-module ground_scroll_ctrl holds the state machine and scroll_offset register; inputs are frame_tick, start and game_over.
- The top level holds the coordinate mapping, the 3-stage pipeline and the compositing mux.

## Test plan
- Reset, then pix_y=GROUND_Y, pix_x=5, offset 0 → sprite_y=0 one cycle later and sprite_x=5 two cycles later. With a ROM model returning mask=1 and rgb=AA/BB/CC, out = AA/BB/CC at cycle 3 with out_valid=1.
- pix_y=GROUND_Y−1 with bg=10/20/30 → out=10/20/30; sprite_x/sprite_y stay 0.
- start, then 8 frame_ticks with SPEED=2 → offset sequence 2, 4, …, 14, 0 (wrap). pix_x=3 on the band then gives sprite_x=3 at offset 0 and sprite_x=9 at offset 6.
- In RUN, assert start and game_over in the same cycle → state=HALT. Further frame_ticks leave the offset unchanged. A later start → IDLE with offset=0.
- In-band pixel with tile_mask=0 → out equals bg. A pixel with pix_valid=0 → out=0 and out_valid=0.
- Assert rst_n=0 mid-stream with the pipeline full → all outputs 0 immediately. After release, the first out_valid appears exactly 3 cycles after pix_valid.
